// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order pixel stream.
// Partial maxima of even rows are kept in a half-width line buffer.
module relu_maxpool2x2 #(
  parameter int DATA_W = 22,
  parameter int MAP_W  = 4,
  parameter int MAP_H  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = $clog2(MAP_W);
  localparam int RW = $clog2(MAP_H);
  localparam int LB = MAP_W / 2;
  localparam int HW = (LB > 1) ? $clog2(LB) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept;
  logic              col_last;
  logic              row_last;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] lb_q;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] linebuf [LB];
  logic [HW-1:0]     lb_idx;

  assign lb_idx   = HW'(col >> 1);
  assign col_last = (col == CW'(MAP_W - 1));
  assign row_last = (row == RW'(MAP_H - 1));
  assign accept   = (state == RUN) && in_valid && !start;
  assign r        = in_data[DATA_W-1] ? '0 : in_data;
  assign pair_max = (pair_reg > r) ? pair_reg : r;
  assign lb_q     = linebuf[lb_idx];
  assign win_max  = (lb_q > pair_max) ? lb_q : pair_max;
  assign busy     = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (accept && row_last && col_last) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (col[0] && row[0]) begin
          out_data   <= win_max;
          out_valid  <= 1'b1;
          frame_done <= row_last && col_last;
        end
      end
    end
  end

  // Pair and line-buffer contents are only read after being written in-frame
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0])     pair_reg        <= r;
      else if (!row[0]) linebuf[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2 on a 4x4 map.
// Outputs are captured on the falling edge and compared to hand-computed values.
module tb_relu_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [21:0] in_data;
  logic        out_valid;
  logic [21:0] out_data;
  logic        frame_done;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int oq[$];
  int fq[$];
  int cq[$];
  int closeq[$];
  int frame[16];

  relu_maxpool2x2 #(.DATA_W(22), .MAP_W(4), .MAP_H(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back(int'(out_data));
      fq.push_back(int'(frame_done));
      cq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    oq.delete();
    fq.delete();
    cq.delete();
    closeq.delete();
  endtask

  task automatic px(input int v, input int gap);
    in_data  = v[21:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int gapmax);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      in_data  = frame[i][21:0];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if ((i % 2 == 1) && ((i / 4) % 2 == 1)) closeq.push_back(cyc);
      repeat (g) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outs(input string tag,
                            input int a, input int b,
                            input int c, input int d);
    int e[4];
    int fd;
    e  = '{a, b, c, d};
    fd = 0;
    check({tag, "_cnt"}, oq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < oq.size()) check($sformatf("%s_v%0d", tag, i), oq[i], e[i]);
    foreach (fq[i]) fd += fq[i];
    check({tag, "_fd_cnt"}, fd, 1);
    if (fq.size() > 0) check({tag, "_fd_last"}, fq[fq.size()-1], 1);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ov", int'(out_valid), 0);
    check("rst_od", int'(out_data), 0);
    check("rst_fd", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: ramp frame
    for (int i = 0; i < 16; i++) frame[i] = i;
    clear_q();
    do_start();
    check("t1_busy_run", int'(busy), 1);
    run_frame(0);
    check_outs("t1", 5, 7, 13, 15);
    for (int i = 0; i < 4; i++)
      if (i < cq.size() && i < closeq.size())
        check($sformatf("t1_lat%0d", i), cq[i], closeq[i]);

    // 2: all negative
    for (int i = 0; i < 16; i++) frame[i] = -(i + 1);
    clear_q();
    do_start();
    run_frame(0);
    check_outs("t2", 0, 0, 0, 0);

    // 3: extremes
    frame = '{-2097152, 2097151, -2097152, -2097152,
              0,        5,       -2097152, -2097152,
              0, 0, 0, 0,
              0, 0, 0, 0};
    clear_q();
    do_start();
    run_frame(0);
    check_outs("t3", 2097151, 0, 0, 0);

    // 4: ramp with random gaps
    for (int i = 0; i < 16; i++) frame[i] = i;
    clear_q();
    do_start();
    run_frame(3);
    check_outs("t4", 5, 7, 13, 15);
    for (int i = 0; i < 4; i++)
      if (i < cq.size() && i < closeq.size())
        check($sformatf("t4_lat%0d", i), cq[i], closeq[i]);

    // 5: restart after 9 pixels
    clear_q();
    do_start();
    for (int i = 0; i < 9; i++) px(i + 100, 0);
    check("t5_partial_cnt", oq.size(), 2);
    clear_q();
    do_start();
    run_frame(0);
    check_outs("t5a", 5, 7, 13, 15);

    // 5b: start with in_valid drops that pixel
    clear_q();
    do_start();
    for (int i = 0; i < 3; i++) px(50, 0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 22'd100;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    run_frame(0);
    check_outs("t5b", 5, 7, 13, 15);

    // 6: reset mid-frame
    clear_q();
    do_start();
    for (int i = 0; i < 10; i++) px(i, 0);
    check("t6_pre_cnt", oq.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ov", int'(out_valid), 0);
    check("t6_od", int'(out_data), 0);
    check("t6_fd", int'(frame_done), 0);
    check("t6_busy", int'(busy), 0);
    clear_q();
    for (int i = 0; i < 8; i++) px(i + 20, 0);
    repeat (3) @(negedge clk);
    check("t6_idle_cnt", oq.size(), 0);
    check("t6_idle_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
